lsu: RTL and testbench
======================

# lsu

Load/store unit between the CPU MEM stage and the word-addressed data memory `dm`. It turns byte, halfword and word loads/stores on 32-bit byte addresses into word accesses on `dm`. Loads are sign- or zero-extended. Sub-word stores are done as a two-cycle read-modify-write, and the pipeline is stalled for the first cycle. Misaligned accesses are flagged and never reach memory.

## Interface
- `DM_AW`, 7: `dm` word-address width; `dm_addr = addr[DM_AW+1:2]`.
- `clk` in 1: the single clock; `dm` shares it.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 1: MEM-stage access valid.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_ld` in 1: 1 = zero-extend loads (lbu/lhu).
- `addr` in 32: byte address; bits above `DM_AW+1` ignored (aliasing).
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: extended load result.
- `stall` out 1: hold the MEM stage and keep `req`/inputs stable.
- `done` out 1: access finished this cycle.
- `misalign` out 1: access rejected this cycle.
- `dm_addr` out DM_AW; `dm_read` out 1; `dm_write` out 1; `dm_wdata` out 32; `dm_rdata` in 32: connect to `dm` Addr/Read/Write/W_data/R_data.

## Operation
- Little-endian. Byte lane k is bits [8k+7:8k], with k = `addr[1:0]`. A halfword at `addr[1]` uses bits [16h+15:16h].
- Alignment: a half needs `addr[0]`=0 and a word needs `addr[1:0]`=0. `size`=11 is always illegal.
- FSM states are IDLE and RMW_WR. Registers: `state`, `merge_q` (32), `addr_q` (DM_AW), and request fields.
- IDLE, no `req`: all strobes 0, `rdata`=0.
- IDLE, illegal or misaligned `req`: `misalign`=1, `done`=1, `dm_read`=`dm_write`=0, `stall`=0. State stays IDLE.
- IDLE, load: `dm_read`=1. `rdata` is the selected lane(s), extended according to `unsigned_ld`. `done`=1 in the same cycle and the state stays IDLE.
- IDLE, word store: `dm_write`=1 and `dm_wdata`=`wdata`. `done`=1 and the state stays IDLE.
- IDLE, byte/half store: `dm_read`=1 and `stall`=1. At the clock edge, `merge_q` takes `dm_rdata` with the target lane(s) replaced by `wdata[7:0]`/`wdata[15:0]`. `addr_q` is latched and the state goes to RMW_WR.
- RMW_WR: `dm_addr`=`addr_q`, `dm_write`=1, `dm_wdata`=`merge_q`, `done`=1, `stall`=0. Inputs are ignored. The next state is IDLE.
- `stall` is high only in the IDLE sub-word-store cycle.

## Timing
- Reset: while `rst_n`=0, all outputs (`rdata`, `dm_*`, `stall`, `done`, `misalign`) are forced to 0. At the edge, `state`→IDLE and `merge_q`/`addr_q`→0.
- Reset mid-RMW: when `rst_n`=0 in RMW_WR, `dm_write` is gated to 0. No partial write commits and the state returns to IDLE.
- Load latency is 0 cycles (combinational through `dm`).
- Word store commits at the edge that ends its request cycle.
- Sub-word store takes 2 cycles: the read in cycle 1, the commit at the edge ending cycle 2.
- Back-to-back: the request after RMW_WR is accepted in the very next cycle.
- A load of a word written in the immediately preceding cycle returns the new data. No hazard logic is needed.
- `done` and `misalign` are single-cycle, per-access indications.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=1, `we`=1, `size`=10 → `dm_write`=0 and all outputs 0. Memory is unchanged and the unit is in IDLE after release.
- Word: store 0xDEADBEEF at 0x10 → same cycle `dm_addr`=4, `dm_write`=1, `stall`=0. Then lw 0x10 → `rdata`=0xDEADBEEF with `done`=1.
- Byte: word 0x11223344 at 0x10, sb 0x13 with `wdata`=0xA5.
  - Cycle 1: `stall`=1, `dm_read`=1.
  - Cycle 2: `dm_write`=1, `dm_wdata`=0xA5223344.
  - Then lb 0x13 → 0xFFFFFFA5, and lbu 0x13 → 0x000000A5.
- Half: word 0x11223344 at 0x10, sh 0x12 with `wdata`=0x8001 → `dm_wdata`=0x80013344. Then lh 0x12 → 0xFFFF8001, and lhu 0x12 → 0x00008001.
- Misalign:
  - lw 0x06, sh 0x01, and `size`=11 each give `misalign`=1, `done`=1, and no `dm_read`/`dm_write`.
  - The next aligned request completes normally.
- Reset mid-RMW: sb 0x10 with `wdata`=0x77 onto 0x11223344, and `rst_n`=0 during RMW_WR → no write. The memory word stays 0x11223344 and the unit is in IDLE.

Source files
------------

// File: rtl/lsu.sv
// lsu: byte/half/word load-store unit over a word-addressed data memory,
// with sign/zero-extended loads and two-cycle read-modify-write sub-word stores.
module lsu #(
  parameter int DM_AW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [DM_AW-1:0]  dm_addr,
  output logic              dm_read,
  output logic              dm_write,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
  typedef enum logic {IDLE, RMW_WR} state_t;
  state_t state, state_n;
  logic [31:0] merge_q, merge_d;
  logic [DM_AW-1:0] addr_q, addr_d;
  logic legal;
  logic [4:0] sh;
  logic [31:0] lane, bmask, ld, merged;
  logic unused_addr;
  assign unused_addr = ^addr[31:DM_AW+2];
  assign legal = (size == 2'b00) || (size == 2'b01 && !addr[0]) || (size == 2'b10 && addr[1:0] == 2'b00);
  assign sh    = size == 2'b00 ? {addr[1:0], 3'b000} : {addr[1], 4'b0000};
  assign lane  = dm_rdata >> sh;
  assign bmask = (size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign ld    = size == 2'b00 ? {{24{~unsigned_ld & lane[7]}}, lane[7:0]} :
                 size == 2'b01 ? {{16{~unsigned_ld & lane[15]}}, lane[15:0]} : dm_rdata;
  assign merged = (dm_rdata & ~bmask) | ((wdata << sh) & bmask);
  always_comb begin
    state_n  = state;
    merge_d  = merge_q;
    addr_d   = addr_q;
    rdata    = '0;
    stall    = 1'b0;
    done     = 1'b0;
    misalign = 1'b0;
    dm_addr  = addr[DM_AW+1:2];
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_wdata = '0;
    if (state == RMW_WR) begin
      dm_addr  = addr_q;
      dm_write = 1'b1;
      dm_wdata = merge_q;
      done     = 1'b1;
      state_n  = IDLE;
    end else if (req) begin
      if (!legal) begin
        misalign = 1'b1;
        done     = 1'b1;
      end else if (!we) begin
        dm_read = 1'b1;
        rdata   = ld;
        done    = 1'b1;
      end else if (size == 2'b10) begin
        dm_write = 1'b1;
        dm_wdata = wdata;
        done     = 1'b1;
      end else begin
        dm_read = 1'b1;
        stall   = 1'b1;
        merge_d = merged;
        addr_d  = addr[DM_AW+1:2];
        state_n = RMW_WR;
      end
    end
    // reset gates every output, which also cancels an in-flight RMW commit
    if (!rst_n) begin
      rdata    = '0;
      stall    = 1'b0;
      done     = 1'b0;
      misalign = 1'b0;
      dm_addr  = '0;
      dm_read  = 1'b0;
      dm_write = 1'b0;
      dm_wdata = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      state   <= state_n;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed checks of lsu against a behavioural word memory.
module tb_lsu;
  logic clk = 1'b0, rst_n, req, we, unsigned_ld;
  logic [1:0] size;
  logic [31:0] addr, wdata, rdata, dm_wdata, dm_rdata;
  logic stall, done, misalign, dm_read, dm_write;
  logic [6:0] dm_addr;
  logic [31:0] mem [0:127];
  int checks = 0, errors = 0;

  lsu #(.DM_AW(7)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .misalign(misalign),
    .dm_addr(dm_addr), .dm_read(dm_read), .dm_write(dm_write), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge clk) if (dm_write) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = mem[dm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic r, input logic w, input logic [1:0] s,
                     input logic u, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst_n = rn; req = r; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
    @(negedge clk);
  endtask

  function automatic logic [31:0] strobes();
    return {27'd0, dm_read, dm_write, stall, done, misalign};
  endfunction

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D);
      chk("rst_strobes", strobes(), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_dm_addr", {25'd0, dm_addr}, 0);
      chk("rst_dm_wdata", dm_wdata, 0);
    end
    cyc(1, 0, 0, 2'b00, 0, 32'h10, 0);
    chk("idle_strobes", strobes(), 0);
    chk("idle_rdata", rdata, 0);
    chk("rst_mem_unchanged", mem[4], 0);
    cyc(1, 1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    chk("sw_dm_addr", {25'd0, dm_addr}, 4);
    chk("sw_strobes", strobes(), 32'b01010);
    chk("sw_dm_wdata", dm_wdata, 32'hDEADBEEF);
    cyc(1, 1, 0, 2'b10, 0, 32'h10, 0);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_strobes", strobes(), 32'b10010);
    cyc(1, 1, 1, 2'b10, 0, 32'h10, 32'h11223344);
    cyc(1, 1, 1, 2'b00, 0, 32'h13, 32'h000000A5);
    chk("sb_c1_strobes", strobes(), 32'b10100);
    cyc(1, 1, 1, 2'b00, 0, 32'h13, 32'h000000A5);
    chk("sb_c2_strobes", strobes(), 32'b01010);
    chk("sb_c2_dm_addr", {25'd0, dm_addr}, 4);
    chk("sb_c2_dm_wdata", dm_wdata, 32'hA5223344);
    cyc(1, 1, 0, 2'b00, 0, 32'h13, 0);
    chk("lb_neg", rdata, 32'hFFFFFFA5);
    cyc(1, 1, 0, 2'b00, 1, 32'h13, 0);
    chk("lbu", rdata, 32'h000000A5);
    cyc(1, 1, 0, 2'b00, 0, 32'h10, 0);
    chk("lb_pos", rdata, 32'h00000044);
    cyc(1, 1, 1, 2'b10, 0, 32'h10, 32'h11223344);
    cyc(1, 1, 1, 2'b01, 0, 32'h12, 32'h00008001);
    chk("sh_c1_strobes", strobes(), 32'b10100);
    cyc(1, 1, 1, 2'b01, 0, 32'h12, 32'h00008001);
    chk("sh_c2_dm_wdata", dm_wdata, 32'h80013344);
    cyc(1, 1, 0, 2'b01, 0, 32'h12, 0);
    chk("lh_neg", rdata, 32'hFFFF8001);
    chk("lh_b2b_done", {31'd0, done}, 1);
    cyc(1, 1, 0, 2'b01, 1, 32'h12, 0);
    chk("lhu", rdata, 32'h00008001);
    cyc(1, 1, 0, 2'b10, 0, 32'h06, 0);
    chk("mis_lw_strobes", strobes(), 32'b00011);
    cyc(1, 1, 1, 2'b01, 0, 32'h01, 32'h1234);
    chk("mis_sh_strobes", strobes(), 32'b00011);
    cyc(1, 1, 0, 2'b11, 0, 32'h10, 0);
    chk("mis_size_strobes", strobes(), 32'b00011);
    cyc(1, 1, 0, 2'b10, 0, 32'h10, 0);
    chk("post_mis_strobes", strobes(), 32'b10010);
    chk("post_mis_rdata", rdata, 32'h80013344);
    cyc(1, 1, 1, 2'b10, 0, 32'h10, 32'h11223344);
    cyc(1, 1, 1, 2'b00, 0, 32'h10, 32'h00000077);
    chk("rmw_rst_c1_stall", strobes(), 32'b10100);
    cyc(0, 1, 1, 2'b00, 0, 32'h10, 32'h00000077);
    chk("rmw_rst_strobes", strobes(), 0);
    cyc(1, 1, 0, 2'b10, 0, 32'h10, 0);
    chk("rmw_rst_mem", mem[4], 32'h11223344);
    chk("rmw_rst_idle_lw", rdata, 32'h11223344);
    chk("rmw_rst_idle_strobes", strobes(), 32'b10010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
